// File: rtl/branch_pc_sequencer.sv
// branch_pc_sequencer
//   Owns the program counter, fetches instructions from instruction memory
//   over a req/ack handshake, presents each one to decode/execute, and
//   advances the PC when execute retires it with the branch ALU's step value.
//
// Ports
//   clk, rst_n        system clock (rising edge), async active-low reset
//   imem_req/addr     fetch request and address, held until imem_ack
//   imem_ack/rdata    one-cycle ack with the fetched word in the same cycle
//   instr_valid       instr/instr_pc hold an unretired instruction
//   instr, instr_pc   current instruction and its PC
//   retire            execute is done with the current instruction
//   retire_opcode     opcode of the retiring instruction
//   step_value        branch ALU result for the retiring instruction
//   halted            sequencer parked after retiring HALT_OPCODE
//   retired_cnt       saturating count of retired instructions
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | raise imem_req for the current pc on the next edge
// WAIT_ACK | request outstanding, waiting (unbounded) for imem_ack
// ISSUE    | instruction presented, waiting for retire
// HALT     | parked after HALT_OPCODE retired; only rst_n leaves
module branch_pc_sequencer #(
  parameter int              PC_W        = 8,
  parameter int              INSTR_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]      HALT_OPCODE = 6'b111111
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               retire,
  input  logic [5:0]         retire_opcode,
  input  logic [PC_W-1:0]    step_value,
  output logic               halted,
  output logic [15:0]        retired_cnt
);

  localparam logic [5:0] OP_JR    = 6'b001010;
  localparam logic [5:0] OP_BR_LO = 6'b001000;
  localparam logic [5:0] OP_BR_HI = 6'b001100;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_ACK = 2'd1,
    ISSUE    = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [PC_W-1:0]      pc, pc_nxt;
  logic                 req_nxt;
  logic                 valid_nxt;
  logic [INSTR_W-1:0]   instr_nxt;
  logic [PC_W-1:0]      instr_pc_nxt;
  logic                 halted_nxt;
  logic [15:0]          cnt_nxt;
  logic [PC_W-1:0]      target_pc;

  // pc only changes on retire, so it is stable for the whole request.
  assign imem_addr = pc;

  // Next PC for the retiring instruction. Non-branch opcodes ignore
  // step_value since the ALU output is undefined for them.
  always_comb begin
    target_pc = pc + PC_W'(1);
    if (retire_opcode == OP_JR) begin
      target_pc = step_value;
    end else if (retire_opcode >= OP_BR_LO && retire_opcode <= OP_BR_HI) begin
      target_pc = pc + step_value;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_nxt      = imem_req;
    valid_nxt    = instr_valid;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    halted_nxt   = halted;
    cnt_nxt      = retired_cnt;
    case (state)
      FETCH: begin
        req_nxt   = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (imem_ack) begin
          instr_nxt    = imem_rdata;
          instr_pc_nxt = pc;
          valid_nxt    = 1'b1;
          req_nxt      = 1'b0;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (retire && instr_valid) begin
          pc_nxt    = target_pc;
          valid_nxt = 1'b0;
          if (retired_cnt != 16'hFFFF) begin
            cnt_nxt = retired_cnt + 16'd1;
          end
          if (retire_opcode == HALT_OPCODE) begin
            halted_nxt = 1'b1;
            state_nxt  = HALT;
          end else begin
            state_nxt  = FETCH;
          end
        end
      end
      HALT: begin
        req_nxt    = 1'b0;
        valid_nxt  = 1'b0;
        halted_nxt = 1'b1;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
      retired_cnt <= 16'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      imem_req    <= req_nxt;
      instr_valid <= valid_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      halted      <= halted_nxt;
      retired_cnt <= cnt_nxt;
    end
  end

endmodule
